regfile_fwd_sb: RTL and testbench

Parametrised integer register file for the decode stage. It provides configurable read ports, a prioritised multi-source bypass network and a pending-write scoreboard that raises per-port hazards and a global stall. It replaces the fixed 32-entry, 2-read, 2-source file-plus-forward logic in decode. It supports RV32E (16 registers), resettable state and load-use stall generation.

---
 rtl/regfile_fwd_sb.sv | 156 +++++++++++++++
 tb/tb_regfile_fwd_sb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_fwd_sb.sv
// regfile_fwd_sb: decode-stage integer register file with a prioritised
// bypass network and a pending-write scoreboard that flags operands whose
// producer has issued but not yet written back.
module regfile_fwd_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NFWD = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NRD*5-1:0]      rd_addr_i,
    output logic [NRD*XLEN-1:0]   rd_data_o,
    output logic [NRD-1:0]        rd_illegal_o,
    output logic [NRD-1:0]        rd_hazard_o,
    output logic                  stall_o,
    input  logic                  wr_en_i,
    input  logic [4:0]            wr_addr_i,
    input  logic [XLEN-1:0]       wr_data_i,
    input  logic [NFWD-1:0]       fwd_en_i,
    input  logic [NFWD-1:0]       fwd_rdy_i,
    input  logic [NFWD*5-1:0]     fwd_addr_i,
    input  logic [NFWD*XLEN-1:0]  fwd_data_i,
    input  logic                  issue_en_i,
    input  logic [4:0]            issue_addr_i,
    input  logic                  flush_i,
    output logic [$clog2(NREG):0] sb_busy_o
);

    localparam int AW = $clog2(NREG);
    localparam int BW = AW + 1;

    // Only the RV32I and RV32E register counts are meaningful here.
    if (NREG != 32 && NREG != 16) begin : g_bad_nreg
        $error("regfile_fwd_sb: NREG must be 32 or 16");
    end

    // Address exists in this configuration.
    function automatic logic is_legal(input logic [4:0] a);
        return 32'(a) < 32'(NREG);
    endfunction

    // Address names a real, writable register (legal and not x0).
    function automatic logic is_writable(input logic [4:0] a);
        return is_legal(a) && (a != 5'd0);
    endfunction

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;
    logic [BW-1:0]   busy_nxt;
    logic            wr_ok;
    logic            issue_ok;

    assign wr_ok    = wr_en_i && is_writable(wr_addr_i);
    // A stalled decode stage cannot really issue, so the request is dropped.
    assign issue_ok = issue_en_i && is_writable(issue_addr_i) && !stall_o;
    assign stall_o  = |rd_hazard_o;

    // Per-port operand selection: x0/illegal, youngest bypass, write-through, file.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a bit unassigned; otherwise synthesis infers latches.
        rd_data_o    = '0;
        rd_illegal_o = '0;
        rd_hazard_o  = '0;
        for (int p = 0; p < NRD; p++) begin
            logic [4:0]      a;
            logic            fwd_hit;
            logic            fwd_rdy;
            logic [XLEN-1:0] fwd_val;
            logic            wb_hit;
            a       = rd_addr_i[5*p +: 5];
            fwd_hit = 1'b0;
            fwd_rdy = 1'b0;
            fwd_val = '0;
            wb_hit  = 1'b0;
            if (!is_legal(a)) begin
                rd_illegal_o[p] = 1'b1;
            end else if (a != 5'd0) begin
                // Scan oldest to youngest so the lowest index overrides.
                for (int i = NFWD - 1; i >= 0; i--) begin
                    if (fwd_en_i[i] && fwd_addr_i[5*i +: 5] == a) begin
                        fwd_hit = 1'b1;
                        fwd_rdy = fwd_rdy_i[i];
                        fwd_val = fwd_data_i[XLEN*i +: XLEN];
                    end
                end
                wb_hit = wr_en_i && (wr_addr_i == a);
                if (fwd_hit) begin
                    rd_data_o[XLEN*p +: XLEN] = fwd_val;
                end else if (wb_hit) begin
                    rd_data_o[XLEN*p +: XLEN] = wr_data_i;
                end else begin
                    rd_data_o[XLEN*p +: XLEN] = rf[a[AW-1:0]];
                end
                rd_hazard_o[p] = (fwd_hit && !fwd_rdy) ||
                                 (pending[a[AW-1:0]] && !fwd_hit && !wb_hit);
            end
            if (rst_i) begin
                rd_hazard_o[p] = 1'b0;
            end
        end
    end

    // Scoreboard next state: flush clears all, writeback clears, issue sets last.
    always_comb begin
        pending_nxt = pending;
        if (flush_i) begin
            pending_nxt = '0;
        end else begin
            if (wr_ok) begin
                pending_nxt[wr_addr_i[AW-1:0]] = 1'b0;
            end
            if (issue_ok) begin
                pending_nxt[issue_addr_i[AW-1:0]] = 1'b1;
            end
        end
        pending_nxt[0] = 1'b0;
    end

    // Population count of the next pending vector, registered as sb_busy_o.
    always_comb begin
        busy_nxt = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_nxt = busy_nxt + BW'(pending_nxt[r]);
        end
    end

    // Register file storage; x0 and out-of-range writes are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the whole array is reset because software relies on a
            // zeroed file; this forces plain flops instead of a RAM macro.
            for (int r = 0; r < NREG; r++) begin
                rf[r] <= '0;
            end
        end else if (wr_ok) begin
            // NOTE: state updates use non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            rf[wr_addr_i[AW-1:0]] <= wr_data_i;
        end
    end

    // Scoreboard and busy counter state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending   <= '0;
            sb_busy_o <= '0;
        end else begin
            pending   <= pending_nxt;
            sb_busy_o <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Directed bench for regfile_fwd_sb: one 3-read-port RV32I instance and one
// 2-read-port RV32E instance share clock and reset.
module tb_regfile_fwd_sb;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Instance A: NREG=32, NRD=3
    logic [14:0] a_rd_addr;
    logic [95:0] a_rd_data;
    logic [2:0]  a_rd_illegal;
    logic [2:0]  a_rd_hazard;
    logic        a_stall;
    logic        a_wr_en;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [1:0]  a_fwd_en;
    logic [1:0]  a_fwd_rdy;
    logic [9:0]  a_fwd_addr;
    logic [63:0] a_fwd_data;
    logic        a_issue_en;
    logic [4:0]  a_issue_addr;
    logic        a_flush;
    logic [5:0]  a_sb_busy;

    // Instance B: NREG=16 (RV32E), NRD=2
    logic [9:0]  b_rd_addr;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_illegal;
    logic [1:0]  b_rd_hazard;
    logic        b_stall;
    logic        b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [1:0]  b_fwd_en;
    logic [1:0]  b_fwd_rdy;
    logic [9:0]  b_fwd_addr;
    logic [63:0] b_fwd_data;
    logic        b_issue_en;
    logic [4:0]  b_issue_addr;
    logic        b_flush;
    logic [4:0]  b_sb_busy;

    regfile_fwd_sb #(.XLEN(32), .NREG(32), .NRD(3), .NFWD(2)) u_dut_a (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data),
        .rd_illegal_o(a_rd_illegal), .rd_hazard_o(a_rd_hazard), .stall_o(a_stall),
        .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
        .fwd_en_i(a_fwd_en), .fwd_rdy_i(a_fwd_rdy),
        .fwd_addr_i(a_fwd_addr), .fwd_data_i(a_fwd_data),
        .issue_en_i(a_issue_en), .issue_addr_i(a_issue_addr),
        .flush_i(a_flush), .sb_busy_o(a_sb_busy)
    );

    regfile_fwd_sb #(.XLEN(32), .NREG(16), .NRD(2), .NFWD(2)) u_dut_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data),
        .rd_illegal_o(b_rd_illegal), .rd_hazard_o(b_rd_hazard), .stall_o(b_stall),
        .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
        .fwd_en_i(b_fwd_en), .fwd_rdy_i(b_fwd_rdy),
        .fwd_addr_i(b_fwd_addr), .fwd_data_i(b_fwd_data),
        .issue_en_i(b_issue_en), .issue_addr_i(b_issue_addr),
        .flush_i(b_flush), .sb_busy_o(b_sb_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        a_rd_addr = '0; a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0;
        a_fwd_en = '0; a_fwd_rdy = '0; a_fwd_addr = '0; a_fwd_data = '0;
        a_issue_en = 0; a_issue_addr = '0; a_flush = 0;
        b_rd_addr = '0; b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0;
        b_fwd_en = '0; b_fwd_rdy = '0; b_fwd_addr = '0; b_fwd_data = '0;
        b_issue_en = 0; b_issue_addr = '0; b_flush = 0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("init_busy_a", a_sb_busy, 6'd0);
        check("init_busy_b", b_sb_busy, 5'd0);

        // ---- Reset and x0 ----
        a_wr_en = 1; a_wr_addr = 5'd5; a_wr_data = 32'h1234;
        tick();
        a_wr_en = 0;
        a_rd_addr = {5'd0, 5'd0, 5'd5};
        #1;
        check("preload_x5", a_rd_data[31:0], 32'h1234);
        a_rd_addr = '0;
        a_issue_en = 1; a_issue_addr = 5'd6;
        tick();
        a_issue_en = 0;
        a_rd_addr = {5'd0, 5'd6, 5'd5};
        #1;
        check("issue_x6_busy", a_sb_busy, 6'd1);
        check("x6_hazard", a_rd_hazard, 3'b010);
        rst_i = 1;
        a_issue_en = 1; a_issue_addr = 5'd8;
        a_wr_en = 1; a_wr_addr = 5'd5; a_wr_data = 32'hBEEF;
        #1;
        check("rst_forces_hazard0", a_rd_hazard, 3'b000);
        check("rst_forces_stall0", a_stall, 1'b0);
        tick();
        rst_i = 0;
        a_issue_en = 0; a_wr_en = 0;
        #1;
        check("rst_x5_zero", a_rd_data[31:0], 32'h0);
        check("rst_busy_zero", a_sb_busy, 6'd0);
        check("rst_x6_no_hazard", a_rd_hazard, 3'b000);
        a_wr_en = 1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFF_FFFF;
        a_rd_addr = '0;
        #1;
        check("x0_writethrough_zero", a_rd_data[31:0], 32'h0);
        tick();
        a_wr_en = 0;
        #1;
        check("x0_read_zero", a_rd_data[31:0], 32'h0);
        check("x0_no_hazard", a_rd_hazard, 3'b000);

        // ---- Bypass priority ----
        a_wr_en = 1; a_wr_addr = 5'd7; a_wr_data = 32'd1;
        tick();
        a_wr_data = 32'd2;
        a_fwd_en = 2'b11; a_fwd_rdy = 2'b11;
        a_fwd_addr = {5'd7, 5'd7};
        a_fwd_data = {32'd3, 32'd4};
        a_rd_addr = {5'd0, 5'd0, 5'd7};
        #1;
        check("byp_fwd0_wins", a_rd_data[31:0], 32'd4);
        a_fwd_en = 2'b10;
        #1;
        check("byp_fwd1_wins", a_rd_data[31:0], 32'd3);
        a_fwd_en = 2'b00;
        #1;
        check("byp_wb_wins", a_rd_data[31:0], 32'd2);
        a_wr_en = 0;
        #1;
        check("byp_rf", a_rd_data[31:0], 32'd1);
        a_fwd_rdy = '0; a_fwd_addr = '0; a_fwd_data = '0;
        a_rd_addr = '0;

        // ---- Load-use ----
        a_issue_en = 1; a_issue_addr = 5'd9;
        tick();
        a_issue_en = 0;
        #1;
        check("lu_busy1", a_sb_busy, 6'd1);
        a_fwd_en = 2'b01; a_fwd_rdy = 2'b00; a_fwd_addr = {5'd0, 5'd9};
        a_fwd_data = {32'd0, 32'hDEAD};
        a_rd_addr = {5'd0, 5'd0, 5'd9};
        #1;
        check("lu_hazard", a_rd_hazard, 3'b001);
        check("lu_stall", a_stall, 1'b1);
        a_issue_en = 1; a_issue_addr = 5'd10;
        tick();
        a_issue_en = 0;
        #1;
        check("lu_issue_blocked", a_sb_busy, 6'd1);
        a_fwd_rdy = 2'b01; a_fwd_data = {32'd0, 32'hAB};
        #1;
        check("lu_ready_hazard", a_rd_hazard, 3'b000);
        check("lu_ready_data", a_rd_data[31:0], 32'hAB);
        a_fwd_en = '0; a_fwd_rdy = '0; a_fwd_addr = '0; a_fwd_data = '0;
        a_wr_en = 1; a_wr_addr = 5'd9; a_wr_data = 32'hAB;
        tick();
        a_wr_en = 0;
        #1;
        check("lu_wb_busy0", a_sb_busy, 6'd0);
        check("lu_wb_rf", a_rd_data[31:0], 32'hAB);
        a_rd_addr = '0;

        // ---- Scoreboard lifecycle ----
        a_issue_en = 1; a_issue_addr = 5'd3;
        tick();
        #1;
        check("sb_busy_x3", a_sb_busy, 6'd1);
        a_issue_addr = 5'd4;
        tick();
        a_issue_en = 0;
        #1;
        check("sb_busy_x4", a_sb_busy, 6'd2);
        a_wr_en = 1; a_wr_addr = 5'd3; a_wr_data = 32'h33;
        tick();
        #1;
        check("sb_wb_x3", a_sb_busy, 6'd1);
        a_issue_en = 1; a_issue_addr = 5'd3;
        tick();
        a_issue_en = 0; a_wr_en = 0;
        a_rd_addr = {5'd0, 5'd4, 5'd3};
        #1;
        check("sb_set_wins_busy", a_sb_busy, 6'd2);
        check("sb_set_wins_hazard", a_rd_hazard, 3'b011);
        a_rd_addr = '0;
        a_flush = 1; a_issue_en = 1; a_issue_addr = 5'd5;
        tick();
        a_flush = 0; a_issue_en = 0;
        #1;
        check("sb_flush", a_sb_busy, 6'd0);

        // ---- Multi-port ----
        a_issue_en = 1; a_issue_addr = 5'd2;
        tick();
        a_issue_en = 0;
        a_rd_addr = {5'd1, 5'd2, 5'd1};
        #1;
        check("mp_hazard", a_rd_hazard, 3'b010);
        check("mp_stall", a_stall, 1'b1);
        a_wr_en = 1; a_wr_addr = 5'd2; a_wr_data = 32'h55;
        #1;
        check("mp_wb_hazard", a_rd_hazard, 3'b000);
        check("mp_wb_data_p1", a_rd_data[63:32], 32'h55);
        check("mp_x1_data_p2", a_rd_data[95:64], 32'h0);
        tick();
        a_wr_en = 0;
        #1;
        check("mp_wb_busy0", a_sb_busy, 6'd0);

        // ---- RV32E ----
        b_rd_addr = {5'd15, 5'd20};
        #1;
        check("e_illegal", b_rd_illegal, 2'b01);
        check("e_illegal_data", b_rd_data[31:0], 32'h0);
        check("e_illegal_hazard", b_rd_hazard, 2'b00);
        b_wr_en = 1; b_wr_addr = 5'd20; b_wr_data = 32'hDEAD;
        b_issue_en = 1; b_issue_addr = 5'd20;
        tick();
        b_wr_en = 0; b_issue_en = 0;
        b_rd_addr = {5'd20, 5'd4};
        #1;
        check("e_busy_unchanged", b_sb_busy, 5'd0);
        check("e_no_alias_x4", b_rd_data[31:0], 32'h0);
        check("e_illegal_p1", b_rd_illegal, 2'b10);
        b_issue_en = 1; b_issue_addr = 5'd15;
        tick();
        b_issue_en = 0;
        b_rd_addr = {5'd15, 5'd20};
        #1;
        check("e_busy_x15", b_sb_busy, 5'd1);
        check("e_hazard_x15", b_rd_hazard, 2'b10);
        check("e_stall", b_stall, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
